regbank_dump_ctrl: RTL

Debug-side sequencer that reads out the whole register bank and streams it as bytes to the UART transmitter.
- On a start request it walks read address 0..BANK_SIZE-1 through one register-bank read port.
- Each word is captured, split into bytes MSB-first, and each byte is sent with a start/done handshake to the UART TX.
- Sits between the debug unit FSM (start/done) and the register bank plus UART TX. Used only while the pipeline is halted.

---
 rtl/regbank_dump_ctrl_if.sv | 48 ++++
 rtl/regbank_dump_ctrl.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/regbank_dump_ctrl_if.sv
// Bundle of the signals exchanged between the register-bank dump sequencer
// and its environment: debug-unit start/busy/done, one register-bank read
// port, and the byte handshake towards the UART transmitter.
// The sequencer takes the master side; the debug unit, bank and UART TX
// together take the slave side.
interface regbank_dump_ctrl_if #(
   parameter int ADDR_LENGTH = 5,
   parameter int DATA_LENGTH = 32,
   parameter int BYTE_WIDTH  = 8
);

   // Debug-unit side
   logic                   i_start;
   logic                   o_busy;
   logic                   o_done;

   // Register-bank read port (data is combinational from the address)
   logic [ADDR_LENGTH-1:0] o_reg_addr;
   logic [DATA_LENGTH-1:0] i_rgD;

   // UART TX byte handshake
   logic [BYTE_WIDTH-1:0]  o_tx_data;
   logic                   o_tx_start;
   logic                   i_tx_done;

   modport master (
      input  i_start,
      input  i_rgD,
      input  i_tx_done,
      output o_busy,
      output o_done,
      output o_reg_addr,
      output o_tx_data,
      output o_tx_start
   );

   modport slave (
      output i_start,
      output i_rgD,
      output i_tx_done,
      input  o_busy,
      input  o_done,
      input  o_reg_addr,
      input  o_tx_data,
      input  o_tx_start
   );

endinterface

// File: rtl/regbank_dump_ctrl.sv
// Register-bank dump sequencer.
// On a start request it walks the bank from address 0 up to BANK_SIZE-1,
// captures each word, and streams it MSB-first as BYTE_WIDTH-bit bytes to
// the UART transmitter, one start/done handshake per byte. Only used while
// the pipeline is halted, so the bank contents are stable during a dump.
module regbank_dump_ctrl #(
   parameter int BANK_SIZE   = 32,
   parameter int ADDR_LENGTH = 5,
   parameter int DATA_LENGTH = 32,
   parameter int BYTE_WIDTH  = 8
) (
   input  logic                i_clk,
   input  logic                i_rst,
   regbank_dump_ctrl_if.master bus
);

   localparam int BYTES_PER_WORD = DATA_LENGTH / BYTE_WIDTH;
   localparam int CNT_W          = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;

   localparam logic [CNT_W-1:0]       LAST_BYTE = CNT_W'(BYTES_PER_WORD - 1);
   localparam logic [ADDR_LENGTH-1:0] LAST_ADDR = ADDR_LENGTH'(BANK_SIZE - 1);

   typedef enum logic [2:0] {
      S_IDLE,   // waiting for a dump request
      S_LOAD,   // capture the word at the current address
      S_SEND,   // one-cycle transmit request for the current byte
      S_WAIT,   // byte in flight, waiting for the TX acknowledge
      S_NEXT,   // word finished, advance the address or finish
      S_DONE    // one-cycle completion pulse
   } state_t;

   state_t                  state_q;
   state_t                  state_d;

   logic [DATA_LENGTH-1:0]  shift_q;      // current word, next byte at the top
   logic [DATA_LENGTH-1:0]  shift_next;   // word after dropping the byte just sent
   logic [CNT_W-1:0]        byte_cnt_q;   // index of the byte in flight
   logic [ADDR_LENGTH-1:0]  addr_q;       // register being dumped
   logic [BYTE_WIDTH-1:0]   tx_data_q;    // byte presented to the UART

   logic                    last_byte;
   logic                    last_addr;

   assign last_byte  = (byte_cnt_q == LAST_BYTE);
   assign last_addr  = (addr_q == LAST_ADDR);
   assign shift_next = shift_q << BYTE_WIDTH;

   // State register; reset is asynchronous so a dump can be aborted at once
   always_ff @(posedge i_clk or posedge i_rst) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of block ordering.
      if (i_rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic: walk LOAD -> (SEND -> WAIT) x bytes -> NEXT per word
   always_comb begin
      // NOTE: default assignment first so no path leaves state_d unassigned,
      // which would otherwise infer a latch.
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (bus.i_start) begin
               state_d = S_LOAD;
            end
         end
         S_LOAD: begin
            state_d = S_SEND;
         end
         S_SEND: begin
            // An acknowledge arriving together with the request is not ours
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (bus.i_tx_done) begin
               state_d = last_byte ? S_NEXT : S_SEND;
            end
         end
         S_NEXT: begin
            state_d = last_addr ? S_DONE : S_LOAD;
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Datapath: address, byte counter, word shift register and output byte
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         // NOTE: the word shift register is ordinary flops, not a memory
         // array, so it is cleared with the rest to keep reset state defined.
         addr_q     <= '0;
         byte_cnt_q <= '0;
         shift_q    <= '0;
         tx_data_q  <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (bus.i_start) begin
                  addr_q     <= '0;
                  byte_cnt_q <= '0;
               end
            end
            S_LOAD: begin
               // The byte is staged here so it is already valid in the
               // cycle that carries its transmit request.
               shift_q   <= bus.i_rgD;
               tx_data_q <= bus.i_rgD[DATA_LENGTH-1 -: BYTE_WIDTH];
            end
            S_WAIT: begin
               if (bus.i_tx_done && !last_byte) begin
                  byte_cnt_q <= byte_cnt_q + CNT_W'(1);
                  shift_q    <= shift_next;
                  tx_data_q  <= shift_next[DATA_LENGTH-1 -: BYTE_WIDTH];
               end
            end
            S_NEXT: begin
               // The address stops at the last register; it never wraps
               if (!last_addr) begin
                  addr_q     <= addr_q + ADDR_LENGTH'(1);
                  byte_cnt_q <= '0;
               end
            end
            S_DONE: begin
               addr_q <= '0;
            end
            default: begin
            end
         endcase
      end
   end

   // Outputs: pulses are decodes of the registered state, so each lasts
   // exactly one cycle and start/done can never overlap
   always_comb begin
      bus.o_tx_start = (state_q == S_SEND);
      bus.o_done     = (state_q == S_DONE);
      bus.o_busy     = (state_q != S_IDLE);
      bus.o_reg_addr = addr_q;
      bus.o_tx_data  = tx_data_q;
   end

endmodule
